// File: rtl/align_shifter_seq_pkg.sv
// Shared types and constants for the sequential alignment shifter.
package align_shifter_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int W_DEF   = 24;
   localparam int SHW_DEF = 6;

   // Width of a counter that must hold values 0..w inclusive.
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/align_shifter_seq_if.sv
// Request/response handshake bundle for the alignment shifter.
interface align_shifter_seq_if
   import align_shifter_seq_pkg::*;
   #(parameter int W = W_DEF, parameter int SHW = SHW_DEF);

   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   data_in;
   logic [SHW-1:0] shamt;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   data_out;
   logic           sticky;
   logic           busy;

   // Producer/consumer side driving requests and accepting results.
   modport master (
      output in_valid, data_in, shamt, out_ready,
      input  in_ready, out_valid, data_out, sticky, busy
   );

   // Shifter side.
   modport slave (
      input  in_valid, data_in, shamt, out_ready,
      output in_ready, out_valid, data_out, sticky, busy
   );

endinterface

// File: rtl/align_shifter_seq.sv
// Bit-serial right shifter for significand alignment: one bit per cycle,
// shifted-out bits collected into a sticky flag, shift count capped at W.
module align_shifter_seq
   import align_shifter_seq_pkg::*;
   #(parameter int W = W_DEF, parameter int SHW = SHW_DEF)
   (
      input  logic              CLK,
      input  logic              Reset,
      align_shifter_seq_if.slave bus
   );

   localparam int CW = cnt_w(W);

   state_t          state;
   logic [W-1:0]    data_q;
   logic            sticky_q;
   logic [CW-1:0]   cnt_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            busy_q;
   logic [CW-1:0]   cnt_load;

   // Saturate the requested shift at W: anything further only zeroes the data.
   always_comb begin
      cnt_load = '0;
      if (int'(bus.shamt) >= W) cnt_load = CW'(W);
      else                      cnt_load = CW'(bus.shamt);
   end

   // FSM plus datapath; handshake outputs are registered alongside the state.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state       <= IDLE;
         data_q      <= '0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q     <= bus.data_in;
                  sticky_q   <= 1'b0;
                  cnt_q      <= cnt_load;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (cnt_load == '0) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (cnt_q == '0) begin
                  // Unreachable in normal flow; finish without an extra shift.
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  data_q   <= data_q >> 1;
                  sticky_q <= sticky_q | data_q[0];
                  cnt_q    <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.data_out  = data_q;
   assign bus.sticky    = sticky_q;
   assign bus.busy      = busy_q;

endmodule
